// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Encode a one-hot (or all-zero) vector into a binary index; zero maps to 0.
  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority winner search: first set request strictly above Ptr,
// wrapping to the lowest set request, optionally ignoring one requester.
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] Req,
  input  logic [IDX_W-1:0]   Ptr,
  input  logic               Exclude_Valid,
  input  logic [IDX_W-1:0]   Exclude_Idx,
  output logic               Found,
  output logic [IDX_W-1:0]   Winner_Idx
);

  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] req_masked;
  logic               found_hi;
  logic               found_lo;
  logic [IDX_W-1:0]   idx_hi;
  logic [IDX_W-1:0]   idx_lo;

  // Masked pick above Ptr, falling back to the lowest set bit of the full vector.
  always_comb begin
    req_eff = Req;
    if (Exclude_Valid) req_eff[Exclude_Idx] = 1'b0;

    req_masked = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) > Ptr) req_masked[i] = req_eff[i];
    end

    found_hi = 1'b0;
    idx_hi   = '0;
    found_lo = 1'b0;
    idx_lo   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found_hi && req_masked[i]) begin
        found_hi = 1'b1;
        idx_hi   = IDX_W'(i);
      end
      if (!found_lo && req_eff[i]) begin
        found_lo = 1'b1;
        idx_lo   = IDX_W'(i);
      end
    end

    Found      = found_hi | found_lo;
    Winner_Idx = found_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/round_robin_arbiter_8.sv
// 8-requester round-robin arbiter with bounded grant hold and zero-bubble handover.
module round_robin_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD_CYCLES = 16
) (
  input  logic               Clock_In,
  input  logic               Reset_n_In,
  input  logic               Enable_In,
  input  logic [NUM_REQ-1:0] Req_In,
  output logic [NUM_REQ-1:0] Grant_Out,
  output logic [IDX_W-1:0]   Grant_Index_Out,
  output logic               Grant_Valid_Out
);

  localparam logic [7:0] MAX_HOLD = 8'(MAX_HOLD_CYCLES);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [7:0]         cnt_q,   cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic [IDX_W-1:0]   holder_idx;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  assign holder_idx = onehot_to_index(grant_q);

  // In BUSY the holder is excluded, so a preempt never wraps back onto it.
  rr_priority_pick u_pick (
    .Req           (Req_In),
    .Ptr           (ptr_q),
    .Exclude_Valid (state_q == BUSY),
    .Exclude_Idx   (holder_idx),
    .Found         (pick_found),
    .Winner_Idx    (pick_idx)
  );

  // Next-state: grant, hold, handover, preempt or clear.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;

    if (!Enable_In) begin
      state_d = IDLE;
      cnt_d   = '0;
      grant_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_d = BUSY;
            ptr_d   = pick_idx;
            cnt_d   = 8'd1;
            grant_d = NUM_REQ'(1) << pick_idx;
          end
        end
        BUSY: begin
          if (!Req_In[holder_idx]) begin
            if (pick_found) begin
              ptr_d   = pick_idx;
              cnt_d   = 8'd1;
              grant_d = NUM_REQ'(1) << pick_idx;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              grant_d = '0;
            end
          end else if (cnt_q < MAX_HOLD) begin
            cnt_d = cnt_q + 8'd1;
          end else if (pick_found) begin
            ptr_d   = pick_idx;
            cnt_d   = 8'd1;
            grant_d = NUM_REQ'(1) << pick_idx;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          grant_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset; Ptr starts at 7.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q <= IDLE;
      ptr_q   <= '1;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign Grant_Out       = grant_q;
  assign Grant_Index_Out = holder_idx;
  assign Grant_Valid_Out = |grant_q;

endmodule
